keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan sequencer for the 4x4 matrix keypad peripheral. It drives the keypad rows one at a time and samples the columns. Each scan frame is debounced, and the block publishes a stable 16-bit key bitmap plus sticky per-row press interrupts. It sits between the keypad pins and the AHB-Lite keyboard interface: `key_data` and `key_interrupt` feed the interface and the CPU IRQ lines, and the interface returns `key_clear`.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clock cycles per row slot (settle plus sample). Legal range 2..2^20.
- `DEBOUNCE`, default 4: consecutive identical frames required before `key_data` updates. Legal range 1..15.

Ports:
- `clk`, input, 1: single system clock.
- `rstn`, input, 1: asynchronous active-low reset.
- `col`, input, 4: keypad columns, active low (pulled up externally), asynchronous to `clk`.
- `row`, output, 4: keypad row drive, one-cold (exactly one bit low at all times).
- `key_clear`, input, 1: single-cycle pulse that clears all pending `key_interrupt` bits.
- `key_data`, output, 16: debounced key bitmap. Bit 4*r+c is 1 when the key at row r, column c is held.
- `key_interrupt`, output, 4: sticky press-pending flags. Bit r is set by a new press anywhere in row r.
- `frame_done`, output, 1: one-cycle pulse at the end of every full 4-row frame.

## Operation

- `col` passes through a 2-flop synchronizer before any use.
- Slot counter `cnt` runs 0..SCAN_DIV-1 and wraps to 0. The row index `r` (0..3) advances when `cnt` wraps. After row 3 it wraps to row 0.
- Row drive: `row = ~(4'b0001 << r)`.
- Sample point is `cnt == SCAN_DIV-1`. The synchronized columns are inverted and written into `raw[4r+3:4r]`.
- Frame end is the sample point of row 3. At frame end:
  - If the completed `raw` equals `last_raw`: `stable <= min(stable+1, DEBOUNCE)`.
  - Otherwise: `stable <= 1` and `last_raw <= raw`.
  - When the next value of `stable` is at least DEBOUNCE, `key_data <= raw` and `press = raw & ~key_data`.
  - For each row r, if `press[4r+3:4r]` is nonzero, `key_interrupt[r]` is set.
  - `frame_done` pulses for one cycle.
- Releases (1 to 0 transitions in `key_data`) update the bitmap but never set `key_interrupt`.
- `key_clear` clears all four `key_interrupt` bits.
- If `key_clear` and a set for the same bit land in the same cycle, the set wins for that bit. Bits not being set are cleared.
- Multiple simultaneous presses are all reflected in `key_data`. Each affected row's interrupt bit is set.
- Counter widths: `cnt` is clog2(SCAN_DIV) bits and `stable` is 4 bits. Saturation prevents overflow.

## Timing

Reset values (asynchronous, applied immediately while `rstn` = 0):
- `row` = 4'b1110, `cnt` = 0, `r` = 0
- `raw`, `last_raw` and `key_data` = 0
- `stable` = 0
- `key_interrupt` = 0, `frame_done` = 0
- synchronizer flops = 4'b1111

Cycle-level timing:
- Row r is driven for exactly SCAN_DIV cycles. One frame is 4*SCAN_DIV cycles.
- `row` changes on the clock edge that wraps `cnt`. There are no overlap or gap cycles.
- `key_data`, `key_interrupt` and `frame_done` update on the clock edge at frame end and are visible from the following cycle.
- Press latency: a key held stable from the start of frame N appears in `key_data` at the end of frame N+DEBOUNCE-1. Add 2 cycles of synchronizer delay if the press lands within 2 cycles of its row's sample point.
- `key_clear` takes effect on the next edge. The bits read 0 from the following cycle unless set in the same edge.

Boundary conditions:
- A `raw` change that interrupts a stable run restarts the count at 1. `key_data` holds its old value until DEBOUNCE matching frames complete.
- With DEBOUNCE = 1, `key_data` follows every frame.
- Reset asserted mid-frame aborts the partial frame. No `frame_done` is produced. After `rstn` deasserts, scanning restarts at row 0 with `cnt` = 0.

## Test plan

1. **Reset.** Assert `rstn` = 0 mid-slot. Check `row` = 1110, `key_data` = 0, `key_interrupt` = 0 and `frame_done` = 0. After release, `frame_done` first pulses exactly 4*SCAN_DIV+1 cycles later. Use SCAN_DIV = 4 and DEBOUNCE = 2.
2. **Single press.** Keypad model pulls `col[c]` low when `row[r]` is low. Hold key (r=2, c=1) from frame 1. Expect `key_data` = 16'h0200 and `key_interrupt` = 4'b0100 after frame 2 ends. Release the key: after two more frames, `key_data` = 0 and `key_interrupt` stays 4'b0100.
3. **Bounce.** Toggle key (0,0) every frame for 5 frames. `key_data` stays 0 and no interrupt is set. Then hold the key for 2 frames: `key_data` = 16'h0001 and `key_interrupt` = 4'b0001.
4. **Clear collision.** With `key_interrupt` = 4'b0001, pulse `key_clear` in the same cycle as a new press in row 3 is registered. Expect `key_interrupt` = 4'b1000.
5. **Multi-key.** Hold keys (0,3), (1,0) and (3,3) together. Expect `key_data` = 16'h8018 and `key_interrupt` = 4'b1011 after the debounce period. `row` stays one-cold every cycle (assertion).
6. **Reset mid-operation.** Assert reset while `stable` = 1 with a key held. Expect all outputs back at their reset values. After release, the debounce count restarts and the key appears only after 2 full frames.

Source files
------------

// File: rtl/keypad_scan_ctrl_if.sv
// Signal bundle between the keypad pins / AHB keyboard interface and the scan sequencer.
// The master side drives columns and clear; the slave (scanner) drives rows and results.
interface keypad_scan_ctrl_if;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_clear;
  logic [15:0] key_data;
  logic [3:0]  key_interrupt;
  logic        frame_done;

  modport master (
    output col,
    output key_clear,
    input  row,
    input  key_data,
    input  key_interrupt,
    input  frame_done
  );

  modport slave (
    input  col,
    input  key_clear,
    output row,
    output key_data,
    output key_interrupt,
    output frame_done
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-cold row drive, synchronized column sampling, frame-level
// debounce, stable key bitmap and sticky per-row press interrupts.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               rstn,
  keypad_scan_ctrl_if.slave  kif
);

  localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB     = 4'(DEBOUNCE);

  logic [3:0]       col_meta;
  logic [3:0]       col_sync;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       r;
  logic [15:0]      raw;
  logic [15:0]      last_raw;
  logic [15:0]      key_data_reg;
  logic [3:0]       stable;
  logic [3:0]       irq_reg;
  logic             frame_done_reg;

  logic             sample;
  logic             frame_end;
  logic [15:0]      raw_done;
  logic [15:0]      press;
  logic [3:0]       press_row;
  logic [3:0]       stable_next;
  logic             commit;
  logic [3:0]       irq_set;
  logic [3:0]       irq_next;

  assign sample    = (cnt == CNT_MAX);
  assign frame_end = sample && (r == 2'd3);
  // The row 3 nibble is still being sampled on the frame-end edge, so splice it in.
  assign raw_done  = {~col_sync, raw[11:0]};
  assign press     = raw_done & ~key_data_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_press_row
      assign press_row[gi] = |press[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    stable_next = 4'd1;
    if (raw_done == last_raw) begin
      stable_next = (stable >= DEB) ? DEB : stable + 4'd1;
    end
    commit   = (stable_next >= DEB);
    irq_set  = (frame_end && commit) ? press_row : 4'b0000;
    // A set arriving on the same edge as a clear takes priority for that bit.
    irq_next = (kif.key_clear ? 4'b0000 : irq_reg) | irq_set;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= kif.col;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      r   <= 2'd0;
      raw <= '0;
    end else begin
      if (sample) begin
        cnt            <= '0;
        r              <= r + 2'd1;
        raw[4*r +: 4]  <= ~col_sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_raw       <= '0;
      stable         <= '0;
      key_data_reg   <= '0;
      irq_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_end;
      irq_reg        <= irq_next;
      if (frame_end) begin
        stable   <= stable_next;
        last_raw <= raw_done;
        if (commit) begin
          key_data_reg <= raw_done;
        end
      end
    end
  end

  assign kif.row           = ~(4'b0001 << r);
  assign kif.key_data      = key_data_reg;
  assign kif.key_interrupt = irq_reg;
  assign kif.frame_done    = frame_done_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed and randomized frame-level checks of keypad_scan_ctrl against a
// frame-history reference model of the debounce and interrupt rules.
module tb_keypad_scan_ctrl;

  localparam int SD  = 4;
  localparam int DEB = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] keys;
  logic [3:0]  col_drv;
  logic        row_chk_en;

  int checks = 0;
  int errors = 0;

  logic [15:0] hist[$];
  logic [15:0] m_data;
  logic [3:0]  m_int;

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .kif  (kif)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key shorts its column low while its row is driven low.
  always_comb begin
    col_drv = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (!kif.row[rr] && keys[4*rr+cc]) col_drv[cc] = 1'b0;
  end
  assign kif.col = col_drv;

  always @(negedge clk) begin
    if (row_chk_en) begin
      checks++;
      assert ($onehot(~kif.row))
      else begin
        errors++;
        $error("FAIL row_one_cold: got 0x%0h expected exactly one low bit", kif.row);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_data = '0;
    m_int  = '0;
  endtask

  // key_data commits once the last DEB frames are all identical.
  task automatic model_frame(input logic [15:0] f, input bit clr);
    logic [3:0] set;
    bit         all_eq;
    set = '0;
    hist.push_back(f);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_eq = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != f) all_eq = 0;
    if (all_eq) begin
      for (int rr = 0; rr < 4; rr++)
        if ((f[4*rr +: 4] & ~m_data[4*rr +: 4]) != 4'b0) set[rr] = 1'b1;
      m_data = f;
    end
    if (clr) m_int = '0;
    m_int = m_int | set;
  endtask

  // Called at the negedge of a frame's first cycle; returns at the next one.
  // mode 0: plain frame, 1: key_clear mid-frame, 2: key_clear on the frame-end edge.
  task automatic run_frame(input logic [15:0] k, input int mode);
    int n;
    n    = 0;
    keys = k;
    if (mode == 1) begin
      repeat (2) begin @(negedge clk); n++; end
      kif.key_clear = 1'b1;
      @(negedge clk); n++;
      kif.key_clear = 1'b0;
      m_int = '0;
      chk("clear_mid", 32'(kif.key_interrupt), 32'(m_int));
    end
    if (mode == 2) begin
      repeat (4*SD-1) begin @(negedge clk); n++; end
      kif.key_clear = 1'b1;
      @(negedge clk); n++;
      kif.key_clear = 1'b0;
    end else begin
      do begin @(negedge clk); n++; end while (!kif.frame_done && n < 4*SD+4);
    end
    chk("frame_len", 32'(n), 32'(4*SD));
    chk("frame_done", 32'(kif.frame_done), 32'(1));
    model_frame(k, mode == 2);
    chk("key_data", 32'(kif.key_data), 32'(m_data));
    chk("key_interrupt", 32'(kif.key_interrupt), 32'(m_int));
    $display("frame keys=%04h mode=%0d key_data=%04h key_interrupt=%04b", k, mode,
             kif.key_data, kif.key_interrupt);
  endtask

  initial begin
    int          n;
    logic [15:0] rk;
    int          mode;

    row_chk_en    = 1'b0;
    rstn          = 1'b1;
    keys          = '0;
    kif.key_clear = 1'b0;
    model_reset();
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    row_chk_en = 1'b1;

    // Reset asserted mid-slot.
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_row", 32'(kif.row), 32'(4'b1110));
    chk("rst_key_data", 32'(kif.key_data), 32'(0));
    chk("rst_key_interrupt", 32'(kif.key_interrupt), 32'(0));
    chk("rst_frame_done", 32'(kif.frame_done), 32'(0));
    @(posedge clk);
    #1 rstn = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!kif.frame_done && n < 8*SD);
    chk("first_frame_done_cycle", 32'(n), 32'(4*SD+1));
    model_frame(keys, 1'b0);
    chk("key_data", 32'(kif.key_data), 32'(m_data));
    $display("reset: first frame_done in cycle %0d", n);

    // Single press at (2,1), then release.
    run_frame(16'h0200, 0);
    run_frame(16'h0200, 0);
    chk("single_data", 32'(kif.key_data), 32'(16'h0200));
    chk("single_irq", 32'(kif.key_interrupt), 32'(4'b0100));
    run_frame(16'h0000, 0);
    run_frame(16'h0000, 0);
    chk("release_data", 32'(kif.key_data), 32'(0));
    chk("release_irq", 32'(kif.key_interrupt), 32'(4'b0100));
    run_frame(16'h0000, 1);

    // Bounce on (0,0), then a steady hold.
    for (int i = 0; i < 5; i++) begin
      run_frame((i % 2 == 0) ? 16'h0001 : 16'h0000, 0);
      chk("bounce_data", 32'(kif.key_data), 32'(0));
      chk("bounce_irq", 32'(kif.key_interrupt), 32'(0));
    end
    run_frame(16'h0001, 0);
    run_frame(16'h0001, 0);
    chk("hold_data", 32'(kif.key_data), 32'(16'h0001));
    chk("hold_irq", 32'(kif.key_interrupt), 32'(4'b0001));

    // Clear coinciding with a new row 3 press.
    run_frame(16'h1001, 0);
    chk("pre_collide_irq", 32'(kif.key_interrupt), 32'(4'b0001));
    run_frame(16'h1001, 2);
    chk("collide_irq", 32'(kif.key_interrupt), 32'(4'b1000));
    chk("collide_data", 32'(kif.key_data), 32'(16'h1001));

    // Multi-key press.
    run_frame(16'h8018, 0);
    run_frame(16'h8018, 0);
    chk("multi_data", 32'(kif.key_data), 32'(16'h8018));
    chk("multi_irq", 32'(kif.key_interrupt), 32'(4'b1011));

    // Reset while a new key has one matching frame.
    run_frame(16'h0040, 0);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst2_row", 32'(kif.row), 32'(4'b1110));
    chk("rst2_key_data", 32'(kif.key_data), 32'(0));
    chk("rst2_key_interrupt", 32'(kif.key_interrupt), 32'(0));
    chk("rst2_frame_done", 32'(kif.frame_done), 32'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    run_frame(16'h0040, 0);
    chk("rst2_f1_data", 32'(kif.key_data), 32'(0));
    run_frame(16'h0040, 0);
    chk("rst2_f2_data", 32'(kif.key_data), 32'(16'h0040));
    chk("rst2_f2_irq", 32'(kif.key_interrupt), 32'(4'b0010));

    // Randomized frames with occasional key changes and clears.
    rk = 16'h0040;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) rk = 16'($urandom);
      if ($urandom_range(0, 3) == 0)      mode = 2;
      else if ($urandom_range(0, 5) == 0) mode = 1;
      else                                mode = 0;
      run_frame(rk, mode);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
